// File: rtl/axi_lite_cfg_sts.sv
// AXI4-Lite responder: writable 32-bit config bank followed by a read-only status bank.
// Write and read channels are independent two-state machines with fully registered outputs.
module axi_lite_cfg_sts #(
  parameter int unsigned CFG_WORDS  = 16,
  parameter int unsigned STS_WORDS  = 4,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  output logic [CFG_WORDS*32-1:0]   cfg_data,
  output logic [CFG_WORDS-1:0]      cfg_wstb,
  input  logic [STS_WORDS*32-1:0]   sts_data,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [31:0]               s_axi_wdata,
  input  logic [3:0]                s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [31:0]               s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready
);

  localparam int unsigned IW = ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WIdle, WResp} w_state_e;
  typedef enum logic {RIdle, RResp} r_state_e;

  w_state_e                  r_wstate;
  r_state_e                  r_rstate;
  logic                      r_aw_held;
  logic                      r_w_held;
  logic [IW-1:0]             r_aw_idx;
  logic [31:0]               r_wdata;
  logic [3:0]                r_wstrb;
  logic [CFG_WORDS*32-1:0]   r_cfg;
  logic [CFG_WORDS-1:0]      r_wstb;
  logic                      r_awready;
  logic                      r_wready;
  logic                      r_bvalid;
  logic [1:0]                r_bresp;
  logic                      r_arready;
  logic                      r_rvalid;
  logic [31:0]               r_rdata;
  logic [1:0]                r_rresp;

  logic [CFG_WORDS*32-1:0]   w_cfg_next;
  logic [CFG_WORDS-1:0]      w_wstb_next;
  logic                      w_wr_hit;
  logic [IW-1:0]             w_ar_idx;
  logic [31:0]               w_rd_data;
  logic [1:0]                w_rd_resp;
  logic                      w_unused;

  // Address byte-offset bits carry no meaning for word registers.
  assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  assign w_ar_idx = s_axi_araddr[ADDR_WIDTH-1:2];

  // Commit candidate built from the captured AW/W beats.
  always_comb begin
    w_cfg_next  = r_cfg;
    w_wstb_next = '0;
    w_wr_hit    = 1'b0;
    for (int k = 0; k < CFG_WORDS; k++) begin
      if (r_aw_idx == IW'(k)) begin
        w_wr_hit = 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (r_wstrb[b]) begin
            w_cfg_next[32*k+8*b +: 8] = r_wdata[8*b +: 8];
            w_wstb_next[k]            = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_SLVERR;
    for (int k = 0; k < CFG_WORDS; k++) begin
      if (w_ar_idx == IW'(k)) begin
        w_rd_data = r_cfg[32*k +: 32];
        w_rd_resp = RESP_OKAY;
      end
    end
    for (int k = 0; k < STS_WORDS; k++) begin
      if (w_ar_idx == IW'(CFG_WORDS + k)) begin
        w_rd_data = sts_data[32*k +: 32];
        w_rd_resp = RESP_OKAY;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wstate  <= WIdle;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_cfg     <= '0;
      r_wstb    <= '0;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_wstb <= '0;
      if (s_axi_awvalid && r_awready) begin
        r_aw_idx  <= s_axi_awaddr[ADDR_WIDTH-1:2];
        r_aw_held <= 1'b1;
        r_awready <= 1'b0;
      end
      if (s_axi_wvalid && r_wready) begin
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
        r_w_held <= 1'b1;
        r_wready <= 1'b0;
      end
      case (r_wstate)
        WIdle: begin
          if (r_aw_held && r_w_held) begin
            r_cfg    <= w_cfg_next;
            r_wstb   <= w_wstb_next;
            r_bresp  <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
            r_bvalid <= 1'b1;
            r_wstate <= WResp;
          end
        end
        WResp: begin
          if (s_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= WIdle;
          end
        end
      endcase
    end
  end

  // Read sees r_cfg before any same-edge commit, so collisions return the old value.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rstate  <= RIdle;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      case (r_rstate)
        RIdle: begin
          if (s_axi_arvalid) begin
            r_rdata   <= w_rd_data;
            r_rresp   <= w_rd_resp;
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rstate  <= RResp;
          end
        end
        RResp: begin
          if (s_axi_rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= RIdle;
          end
        end
      endcase
    end
  end

  assign cfg_data      = r_cfg;
  assign cfg_wstb      = r_wstb;
  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;

endmodule

// File: tb/tb_axi_lite_cfg_sts.sv
// Bench for axi_lite_cfg_sts: directed scenarios plus random traffic checked against
// an array-based register model.
module tb_axi_lite_cfg_sts;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b1;
  logic [511:0]  cfg_data;
  logic [15:0]   cfg_wstb;
  logic [127:0]  sts_data;
  logic [15:0]   awaddr = '0, araddr = '0;
  logic          awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [31:0]   wdata = '0, rdata;
  logic [3:0]    wstrb = '0;
  logic [1:0]    bresp, rresp;

  int total = 0;
  int bad = 0;
  logic [31:0] m_cfg [16];
  logic [31:0] m_sts [4];

  always #5 aclk = ~aclk;

  always_comb for (int k = 0; k < 4; k++) sts_data[32*k +: 32] = m_sts[k];

  axi_lite_cfg_sts #(.CFG_WORDS(16), .STS_WORDS(4), .ADDR_WIDTH(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_data(cfg_data), .cfg_wstb(cfg_wstb),
    .sts_data(sts_data),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] m_pack();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[32*k +: 32] = m_cfg[k];
    return v;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 16; k++) m_cfg[k] = '0;
  endtask

  // lead > 0: W issued lead cycles before AW; lead < 0: AW first; bdly: cycles bready held low.
  task automatic do_write(input logic [15:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead, input int bdly);
    int          idx;
    logic [1:0]  exp_resp;
    logic [15:0] exp_mask;
    idx      = int'(addr[15:2]);
    exp_resp = (idx < 16) ? 2'b00 : 2'b10;
    exp_mask = '0;
    if (idx < 16 && strb != 4'h0) exp_mask[idx] = 1'b1;
    awaddr = addr; wdata = data; wstrb = strb;
    if (lead == 0) begin
      awvalid = 1; wvalid = 1; tick(); awvalid = 0; wvalid = 0;
    end else if (lead > 0) begin
      wvalid = 1; tick(); wvalid = 0;
      chk("wready_drop", wready, 1'b0);
      repeat (lead - 1) tick();
      awvalid = 1; tick(); awvalid = 0;
    end else begin
      awvalid = 1; tick(); awvalid = 0;
      chk("awready_drop", awready, 1'b0);
      repeat (-lead - 1) tick();
      wvalid = 1; tick(); wvalid = 0;
    end
    chk("bvalid_early", bvalid, 1'b0);
    tick();
    chk("bvalid_set", bvalid, 1'b1);
    chk("bresp", bresp, exp_resp);
    chk("wstb_pulse", cfg_wstb, exp_mask);
    if (idx < 16)
      for (int b = 0; b < 4; b++) if (strb[b]) m_cfg[idx][8*b +: 8] = data[8*b +: 8];
    chk("cfg_after_wr", cfg_data, m_pack());
    for (int i = 0; i < bdly; i++) begin
      tick();
      chk("bvalid_hold", bvalid, 1'b1);
      chk("bresp_hold", bresp, exp_resp);
      chk("ready_low", {awready, wready}, 2'b00);
      chk("wstb_one_cycle", cfg_wstb, 16'h0);
    end
    bready = 1; tick(); bready = 0;
    chk("bvalid_clear", bvalid, 1'b0);
    chk("ready_back", {awready, wready}, 2'b11);
    chk("wstb_idle", cfg_wstb, 16'h0);
  endtask

  task automatic do_read(input logic [15:0] addr, input int rdly);
    int          idx;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    idx = int'(addr[15:2]);
    if (idx < 16) begin
      exp_data = m_cfg[idx]; exp_resp = 2'b00;
    end else if (idx < 20) begin
      exp_data = m_sts[idx-16]; exp_resp = 2'b00;
    end else begin
      exp_data = '0; exp_resp = 2'b10;
    end
    araddr = addr; arvalid = 1; tick(); arvalid = 0;
    for (int i = 0; i <= rdly; i++) begin
      chk("rvalid_set", rvalid, 1'b1);
      chk("arready_low", arready, 1'b0);
      chk("rdata", rdata, exp_data);
      chk("rresp", rresp, exp_resp);
      if (i < rdly) tick();
    end
    rready = 1; tick(); rready = 0;
    chk("rvalid_clear", rvalid, 1'b0);
    chk("arready_back", arready, 1'b1);
  endtask

  initial begin
    logic [31:0] old_val;
    m_reset();
    for (int k = 0; k < 4; k++) m_sts[k] = '0;
    #2 aresetn = 0;
    repeat (3) tick();
    chk("rst_cfg", cfg_data, '0);
    chk("rst_wstb", cfg_wstb, '0);
    chk("rst_ready", {awready, wready, arready}, 3'b111);
    chk("rst_valid", {bvalid, rvalid}, 2'b00);
    chk("rst_resp", {bresp, rresp}, 4'h0);
    chk("rst_rdata", rdata, '0);
    aresetn = 1;
    tick();

    // Full-word write to word1.
    do_write(16'h0004, 32'h0A3D70A4, 4'hF, 0, 0);
    chk("t1_word1", cfg_data[63:32], 32'h0A3D70A4);

    // Partial strobe and readback.
    do_write(16'h0000, 32'hFFFFFFFF, 4'hF, 0, 0);
    do_write(16'h0000, 32'h00000000, 4'b0011, 0, 0);
    chk("t2_word0", cfg_data[31:0], 32'hFFFF0000);
    do_read(16'h0000, 0);
    do_write(16'h0008, 32'h12345678, 4'h0, 0, 0);

    // Status read and write to status.
    m_sts[1] = 32'h00001234;
    #1;
    do_read(16'h0044, 0);
    do_write(16'h0044, 32'hDEADBEEF, 4'hF, 0, 1);

    // W leads AW by 5, bready held low 10 cycles; AW-first skew too.
    do_write(16'h000C, 32'hCAFEF00D, 4'hF, 5, 10);
    do_write(16'h0010, 32'h55AA55AA, 4'b1010, -3, 2);

    // Unmapped read with rready delayed.
    do_read(16'h0100, 4);
    do_read(16'h0053, 1);

    // Read accepted on the same edge as a write commit returns the old value.
    old_val = m_cfg[3];
    awaddr = 16'h000C; wdata = 32'h0BADC0DE; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; tick(); awvalid = 0; wvalid = 0;
    araddr = 16'h000C; arvalid = 1; tick(); arvalid = 0;
    m_cfg[3] = 32'h0BADC0DE;
    chk("coll_bvalid", bvalid, 1'b1);
    chk("coll_rvalid", rvalid, 1'b1);
    chk("coll_rdata_old", rdata, old_val);
    chk("coll_cfg_new", cfg_data, m_pack());
    bready = 1; rready = 1; tick(); bready = 0; rready = 0;
    chk("coll_ready", {awready, wready, arready}, 3'b111);

    // Reset while a write response is pending.
    do_write(16'h0008, 32'h00000008, 4'hF, 0, 0);
    awaddr = 16'h0014; wdata = 32'h77777777; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; tick(); awvalid = 0; wvalid = 0;
    tick();
    chk("t6_bvalid_pending", bvalid, 1'b1);
    aresetn = 0;
    #1;
    m_reset();
    chk("t6_bvalid_drop", bvalid, 1'b0);
    chk("t6_cfg_zero", cfg_data, m_pack());
    chk("t6_ready", {awready, wready, arready}, 3'b111);
    tick();
    aresetn = 1;
    tick();
    do_write(16'h0014, 32'h13579BDF, 4'hF, 0, 0);
    do_read(16'h0014, 0);
    do_read(16'h0008, 0);

    // Random traffic against the model.
    for (int it = 0; it < 80; it++) begin
      int          r;
      int          idx;
      logic [15:0] a;
      r   = int'($urandom_range(0, 9));
      idx = ($urandom_range(0, 15) == 0) ? int'($urandom_range(20, 16383))
                                         : int'($urandom_range(0, 21));
      a   = {idx[13:0], 2'($urandom_range(0, 3))};
      if (r < 2) begin
        m_sts[$urandom_range(0, 3)] = $urandom;
        #1;
      end else if (r < 6) begin
        do_write(a, $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
      end else begin
        do_read(a, int'($urandom_range(0, 3)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
